// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the memory-share arbiter.
// Latency: not applicable (types and pure functions only).
// Backpressure: not applicable.
package sd_arb_pkg;

  // Which access class owns the memory port this cycle.
  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_class_t;

  // Round-robin successor of ptr, wrapping channels-1 back to 0 so that
  // non-power-of-2 channel counts never land on a nonexistent index.
  function automatic int rr_next(input int ptr, input int channels);
    return (ptr >= channels - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, ascending with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
module sd_rr_pick
  import sd_arb_pkg::*;
#(
  parameter int n  = 4,
  parameter int iw = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]  req,
  input  logic [iw-1:0] ptr,
  output logic [n-1:0]  gnt,
  output logic [iw-1:0] idx,
  output logic          any
);

  int cand;

  // Walk n candidates starting at ptr+1; the first asserted request wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = rr_next(int'(ptr), n);
    for (int k = 0; k < n; k++) begin
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = iw'(cand);
      end
      cand = rr_next(cand, n);
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sd_mem_share_arb.sv
// Shares one single-port memory between head (write) and tail (read) controllers.
// Latency: grant and memory strobe in the request cycle; read owner tag one cycle later.
// Backpressure: losing requesters simply stay ungranted; reads are forced through after starve_limit losses.
module sd_mem_share_arb
  import sd_arb_pkg::*;
#(
  parameter int channels     = 4,
  parameter int width        = 8,
  parameter int depth        = 64,
  parameter int asz          = $clog2(depth),
  parameter int starve_limit = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [channels-1:0]       wr_req,
  input  logic [channels*asz-1:0]   wr_addr,
  input  logic [channels*width-1:0] wr_data,
  input  logic [channels-1:0]       rd_req,
  input  logic [channels*asz-1:0]   rd_addr,
  output logic [channels-1:0]       wr_en,
  output logic [channels-1:0]       rd_en,
  output logic                      mem_we,
  output logic                      mem_re,
  output logic [asz-1:0]            mem_addr,
  output logic [width-1:0]          mem_wr_data,
  output logic [channels-1:0]       rd_ch_d1
);

  localparam int cw = (channels > 1) ? $clog2(channels) : 1;
  localparam int sw = $clog2(starve_limit + 1);
  localparam logic [sw-1:0] starve_max = sw'(starve_limit);
  localparam logic [cw-1:0] ptr_init   = cw'(channels - 1);

  logic [cw-1:0]       wr_ptr, rd_ptr;
  logic [sw-1:0]       rd_starve;
  logic [channels-1:0] wr_gnt, rd_gnt;
  logic [cw-1:0]       wr_idx, rd_idx;
  logic                wr_any, rd_any;
  arb_class_t          sel;

  sd_rr_pick #(.n(channels), .iw(cw)) u_wr_pick (
    .req (wr_req),
    .ptr (wr_ptr),
    .gnt (wr_gnt),
    .idx (wr_idx),
    .any (wr_any)
  );

  sd_rr_pick #(.n(channels), .iw(cw)) u_rd_pick (
    .req (rd_req),
    .ptr (rd_ptr),
    .gnt (rd_gnt),
    .idx (rd_idx),
    .any (rd_any)
  );

  // Class select: writes normally win, a starved read wins; nothing while in reset.
  always_comb begin
    sel = ARB_NONE;
    if (reset_n) begin
      if (wr_any && rd_any) begin
        sel = (rd_starve >= starve_max) ? ARB_RD : ARB_WR;
      end else if (wr_any) begin
        sel = ARB_WR;
      end else if (rd_any) begin
        sel = ARB_RD;
      end
    end
  end

  // Only the winning class's one-hot grant reaches its controllers.
  always_comb begin
    wr_en = (sel == ARB_WR) ? wr_gnt : '0;
    rd_en = (sel == ARB_RD) ? rd_gnt : '0;
  end

  // Memory port mux; idle port is driven to zero rather than left holding stale data.
  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (sel)
      ARB_WR: begin
        mem_we      = 1'b1;
        mem_addr    = wr_addr[int'(wr_idx)*asz +: asz];
        mem_wr_data = wr_data[int'(wr_idx)*width +: width];
      end
      ARB_RD: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr[int'(rd_idx)*asz +: asz];
      end
      default: ;
    endcase
  end

  // Round-robin pointers: only the class that won moves, to the index it granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= ptr_init;
      rd_ptr <= ptr_init;
    end else begin
      if (sel == ARB_WR) wr_ptr <= wr_idx;
      if (sel == ARB_RD) rd_ptr <= rd_idx;
    end
  end

  // Read starvation counter: counts lost cycles of a pending read, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_starve <= '0;
    end else if (sel == ARB_RD) begin
      rd_starve <= '0;
    end else if (rd_any && (rd_starve != starve_max)) begin
      rd_starve <= rd_starve + 1'b1;
    end
  end

  // Owner tag for the data the memory returns one cycle after a read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ch_d1 <= '0;
    end else begin
      rd_ch_d1 <= rd_en;
    end
  end

endmodule

// File: doc/sd_mem_share_arb.md
Name: sd_mem_share_arb

Overview:
- Shares one single-port, one-cycle-read-latency memory between `channels` FIFO head/tail controller pairs.
- Each head raises a write request; each tail raises a read request. The block picks at most one access per cycle and drives the selected controller's enable.
- It muxes the winner's address and data onto the memory port.
- It tags the read return with the channel it belongs to, so the tails can steer mem_rd_data.

Parameters:
- channels, 4, number of head/tail controller pairs sharing the memory.
- width, 8, memory data width.
- depth, 64, memory depth in words.
- asz, $clog2(depth), address width.
- starve_limit, 3, number of consecutive cycles a pending read may lose to writes before reads are forced to win.

Ports:
- clk  in  1  clock; all state on posedge clk.
- reset_n  in  1  asynchronous, active-low reset.
- wr_req  in  channels  head i has a word to write; must not depend combinationally on wr_en.
- wr_addr  in  channels*asz  head i write pointer; channel i in bits [i*asz +: asz].
- wr_data  in  channels*width  head i write data.
- rd_req  in  channels  tail i can accept a read (non-empty and buffer space); must not depend combinationally on rd_en.
- rd_addr  in  channels*asz  tail i current read pointer.
- wr_en  out  channels  one-hot enable to head i.
- rd_en  out  channels  one-hot enable to tail i.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  asz  memory address.
- mem_wr_data  out  width  memory write data.
- rd_ch_d1  out  channels  registered one-hot owner of the data on mem_rd_data this cycle.

Behaviour:
- Grants:
  - Combinational from requests and registered state.
  - At most one bit across wr_en|rd_en per cycle; zero grants when wr_req and rd_req are both all-zero.
- Class select, when both classes request:
  - Write wins, unless rd_starve >= starve_limit; then read wins.
  - Only one class requesting: that class wins.
- Within a class: round-robin.
  - Search starts at (ptr+1) mod channels and ascends with wrap.
  - Separate registered pointers wr_ptr and rd_ptr; only the winning class's pointer updates, to the granted index.
  - Non-power-of-2 channels wrap correctly (index channels-1 -> 0).
- rd_starve counter:
  - Width $clog2(starve_limit+1), saturates at starve_limit.
  - Increments when any rd_req is set and no read is granted; clears on any read grant; otherwise holds.
- Memory port:
  - Write grant ch k: mem_we=1, mem_re=0, mem_addr=wr_addr[k], mem_wr_data=wr_data[k].
  - Read grant ch k: mem_re=1, mem_we=0, mem_addr=rd_addr[k].
  - No grant: both strobes 0; mem_addr and mem_wr_data 0.
  - Latency zero from request to memory strobe.
- Read return:
  - rd_ch_d1 <= rd_en every cycle, so it is one-hot exactly one cycle after a read grant, else 0.
  - Back-to-back reads to different channels give consecutive distinct rd_ch_d1 values.
- Request dropped while ungranted: no memory; the next cycle re-arbitrates from the current state.
- Reset (asynchronous, reset_n=0):
  - wr_ptr=rd_ptr=channels-1, so channel 0 is first; rd_starve=0; rd_ch_d1=0.
  - All grants and strobes forced 0 while reset_n=0, regardless of requests.
  - Reset mid-traffic discards the in-flight rd_ch_d1 tag; release resumes from reset state on the first posedge.
- Assertions for the bench: grants one-hot0; a grant implies the matching request; mem_we&mem_re never both 1.

Decomposition:
- Package sd_arb_pkg:
  - Enumerated type arb_class_t {ARB_NONE, ARB_WR, ARB_RD}.
  - Function rr_next(ptr, channels) for the wrap increment.
- Sub-module sd_rr_pick (parameter n):
  - Inputs req[n] and ptr; outputs one-hot gnt[n], idx and any.
  - Instantiated twice, for the write and read classes.
- Top level holds class select, starve counter, pointers, port mux and rd_ch_d1.

Test Plan:
- Reset release with wr_req=4'b0000, rd_req=4'b0001 -> cycle 1: rd_en=0001, mem_re=1, mem_addr=rd_addr[0]; next cycle rd_ch_d1=0001.
- wr_req=4'b1111 held 8 cycles, rd_req=0 -> wr_en sequence 0001,0010,0100,1000,0001,...; each mem_addr matches the granted channel.
- wr_req=4'b0001 and rd_req=4'b0100 held constantly, starve_limit=3 -> pattern W,W,W,R repeating; rd_starve reaches 3 then clears.
- channels=3, rd_req=3'b111 held -> rd_en 001,010,100,001; rd_ch_d1 follows one cycle late.
- reset_n asserted mid-stream while rd_en=0010 -> grants and strobes 0 immediately, rd_ch_d1=0; after release with rd_req=1111 -> first rd_en=0001.
- wr_req=4'b0000, rd_req=4'b0000 for 5 cycles -> mem_we=mem_re=0, rd_starve stays 0, pointers unchanged.
